// File: rtl/qfix_pkg.sv
// Shared sign-magnitude fixed-point definitions for qmult and qaccum.
package qfix_pkg;

    localparam int unsigned DefQ  = 15;            // fractional bits
    localparam int unsigned DefN  = 32;            // word width, bit N-1 is the sign
    localparam int unsigned DefG  = 8;             // accumulator guard bits
    localparam int unsigned DefAW = DefN + DefG;   // accumulator width

    // Largest magnitude representable in an (N,Q) sign-magnitude word.
    localparam logic signed [DefAW-1:0] SatLimit = {{(DefG + 1){1'b0}}, {(DefN - 1){1'b1}}};

    // Sign-magnitude word to sign-extended two's complement; negative zero maps to 0.
    function automatic logic signed [DefAW-1:0] sm2tc(input logic [DefN-1:0] sm);
        logic signed [DefAW-1:0] mag;
        mag = {{(DefG + 1){1'b0}}, sm[DefN-2:0]};
        return sm[DefN-1] ? -mag : mag;
    endfunction

    // Two's complement to sign-magnitude. Caller guarantees |v| <= 2^(N-1)-1,
    // so the magnitude always fits and zero comes out as +0.
    function automatic logic [DefN-1:0] tc2sm(input logic signed [DefN-1:0] v);
        logic [DefN-2:0] mag;
        mag = v[DefN-1] ? (DefN - 1)'(-v) : v[DefN-2:0];
        return {v[DefN-1], mag};
    endfunction

endpackage

// File: rtl/qsat.sv
// Saturates a wide two's complement accumulator into an (N,Q) sign-magnitude word.
module qsat import qfix_pkg::*; #(
    parameter int unsigned N = DefN,
    parameter int unsigned G = DefG
) (
    input  logic signed [N+G-1:0] acc,
    output logic        [N-1:0]   result,
    output logic                  sat
);

    // Clamp to +/-(2^(N-1)-1), otherwise convert the in-range value directly.
    always_comb begin
        result = '0;
        sat    = 1'b0;
        if (acc > SatLimit) begin
            result = {1'b0, {(N - 1){1'b1}}};
            sat    = 1'b1;
        end else if (acc < -SatLimit) begin
            result = {1'b1, {(N - 1){1'b1}}};
            sat    = 1'b1;
        end else begin
            result = tc2sm(acc[N-1:0]);
        end
    end

endmodule

// File: rtl/qaccum.sv
// Dot-product accumulator for sign-magnitude products from qmult.
// Terms arrive over valid/ready; i_last closes a vector and the saturated
// result is held until the consumer takes it.
module qaccum import qfix_pkg::*; #(
    parameter int unsigned N  = DefN,   // must match qfix_pkg widths used by sm2tc/tc2sm
    parameter int unsigned G  = DefG,
    parameter int unsigned CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_data,
    input  logic          i_ovr,
    input  logic          i_last,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [N-1:0]  o_result,
    output logic          o_ovr,
    output logic [CW-1:0] o_count,
    output logic          o_valid,
    input  logic          i_ready
);

    localparam int unsigned AW = N + G;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic signed [AW-1:0] AccMax = {1'b0, {(AW - 1){1'b1}}};
    localparam logic signed [AW-1:0] AccMin = {1'b1, {(AW - 1){1'b0}}};

    logic [1:0]           state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 ovr_q, ovr_d;
    logic [CW-1:0]        count_q, count_d;

    logic                 accept;
    logic signed [AW-1:0] term, acc_base, sum;
    logic                 ovr_base;
    logic [CW-1:0]        count_base;
    logic                 wrap;
    logic [N-1:0]         sat_result;
    logic                 sat;

    assign o_ready = (state_q != StDone);
    assign o_valid = (state_q == StDone);
    assign accept  = i_valid & o_ready;

    // A new vector starts from a clean slate, so IDLE uses zero bases.
    assign term       = sm2tc(i_data);
    assign acc_base   = (state_q == StIdle) ? '0 : acc_q;
    assign ovr_base   = (state_q == StIdle) ? 1'b0 : ovr_q;
    assign count_base = (state_q == StIdle) ? '0 : count_q;
    assign sum        = acc_base + term;
    assign wrap       = (acc_base[AW-1] == term[AW-1]) && (sum[AW-1] != acc_base[AW-1]);

    // Next-state logic for the FSM, accumulator, sticky overflow and term count.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovr_d   = ovr_q;
        count_d = count_q;
        case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    if (wrap) begin
                        acc_d = acc_base[AW-1] ? AccMin : AccMax;
                    end else begin
                        acc_d = sum;
                    end
                    ovr_d   = ovr_base | wrap | i_ovr;
                    count_d = (&count_base) ? count_base : count_base + CW'(1);
                    state_d = i_last ? StDone : StAccum;
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    ovr_d   = 1'b0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                acc_d   = '0;
                ovr_d   = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovr_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovr_q   <= ovr_d;
            count_q <= count_d;
        end
    end

    qsat #(
        .N (N),
        .G (G)
    ) u_qsat (
        .acc    (acc_q),
        .result (sat_result),
        .sat    (sat)
    );

    assign o_result = sat_result;
    assign o_ovr    = ovr_q | sat;
    assign o_count  = count_q;

endmodule

// File: tb/tb_qaccum.sv
// Directed bench for qaccum with hand-computed expected results.
module tb_qaccum;

    localparam int unsigned N  = 32;
    localparam int unsigned CW = 16;

    logic          i_clk;
    logic          i_rst;
    logic [N-1:0]  i_data;
    logic          i_ovr;
    logic          i_last;
    logic          i_valid;
    logic          o_ready;
    logic [N-1:0]  o_result;
    logic          o_ovr;
    logic [CW-1:0] o_count;
    logic          o_valid;
    logic          i_ready;

    int checks;
    int failures;

    qaccum #(
        .N  (N),
        .G  (8),
        .CW (CW)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_data   (i_data),
        .i_ovr    (i_ovr),
        .i_last   (i_last),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_result (o_result),
        .o_ovr    (o_ovr),
        .o_count  (o_count),
        .o_valid  (o_valid),
        .i_ready  (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one beat for a single cycle; inputs change 1ns after the edge.
    task automatic send(input logic [N-1:0] data, input logic ovr, input logic last);
        i_data  = data;
        i_ovr   = ovr;
        i_last  = last;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_ovr   = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [N-1:0] res, input logic ovr,
                                input logic [CW-1:0] cnt);
        check_eq({tag, "_valid"}, 64'(o_valid), 64'd1);
        check_eq({tag, "_result"}, 64'(o_result), 64'(res));
        check_eq({tag, "_ovr"}, 64'(o_ovr), 64'(ovr));
        check_eq({tag, "_count"}, 64'(o_count), 64'(cnt));
    endtask

    task automatic take_result(input string tag);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check_eq({tag, "_drop_valid"}, 64'(o_valid), 64'd0);
        check_eq({tag, "_drop_ready"}, 64'(o_ready), 64'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        i_rst    = 1'b1;
        i_data   = '0;
        i_ovr    = 1'b0;
        i_last   = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("rst_valid", 64'(o_valid), 64'd0);
        check_eq("rst_ready", 64'(o_ready), 64'd1);
        check_eq("rst_result", 64'(o_result), 64'd0);
        check_eq("rst_ovr", 64'(o_ovr), 64'd0);
        check_eq("rst_count", 64'(o_count), 64'd0);
        i_rst = 1'b0;

        // 1.0 + 0.5 - 0.25 = 1.25
        send(32'h0000_8000, 1'b0, 1'b0);
        send(32'h0000_4000, 1'b0, 1'b0);
        send(32'h8000_2000, 1'b0, 1'b1);
        check_result("sum3", 32'h0000_A000, 1'b0, 16'd3);
        take_result("sum3");

        // -1.0 + 0.5 = -0.5
        send(32'h8000_8000, 1'b0, 1'b0);
        send(32'h0000_4000, 1'b0, 1'b1);
        check_result("neg", 32'h8000_4000, 1'b0, 16'd2);
        take_result("neg");

        send(32'h0000_4000, 1'b1, 1'b1);
        check_result("iovr", 32'h0000_4000, 1'b1, 16'd1);
        take_result("iovr");

        send(32'h7FFF_FFFF, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 1'b0, 1'b1);
        check_result("satpos", 32'h7FFF_FFFF, 1'b1, 16'd2);
        take_result("satpos");

        send(32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 1'b0, 1'b1);
        check_result("satneg", 32'hFFFF_FFFF, 1'b1, 16'd2);
        take_result("satneg");

        // Backpressure: a pending beat must not be taken while the result waits.
        send(32'h0000_8000, 1'b0, 1'b1);
        check_result("bp", 32'h0000_8000, 1'b0, 16'd1);
        i_data  = 32'h0000_1000;
        i_last  = 1'b1;
        i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            #1;
            check_eq("bp_hold_valid", 64'(o_valid), 64'd1);
            check_eq("bp_hold_result", 64'(o_result), 64'h0000_8000);
            check_eq("bp_hold_count", 64'(o_count), 64'd1);
            check_eq("bp_hold_ready", 64'(o_ready), 64'd0);
        end
        // Handshake cycle still has i_valid high: the bubble means it is not accepted.
        take_result("bp");
        check_eq("bp_bubble_count", 64'(o_count), 64'd0);
        check_eq("bp_bubble_result", 64'(o_result), 64'd0);
        i_valid = 1'b0;
        i_last  = 1'b0;

        send(32'h8000_0000, 1'b0, 1'b1);
        check_result("negzero", 32'h0000_0000, 1'b0, 16'd1);
        take_result("negzero");

        send(32'h0000_4000, 1'b0, 1'b0);
        send(32'h8000_4000, 1'b0, 1'b1);
        check_result("cancel", 32'h0000_0000, 1'b0, 16'd2);
        take_result("cancel");

        // Reset mid-vector discards the partial sum.
        send(32'h0000_8000, 1'b0, 1'b0);
        send(32'h0000_8000, 1'b0, 1'b0);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check_eq("midrst_valid", 64'(o_valid), 64'd0);
        check_eq("midrst_ready", 64'(o_ready), 64'd1);
        check_eq("midrst_result", 64'(o_result), 64'd0);
        check_eq("midrst_ovr", 64'(o_ovr), 64'd0);
        check_eq("midrst_count", 64'(o_count), 64'd0);
        send(32'h0000_8000, 1'b0, 1'b1);
        check_result("midrst", 32'h0000_8000, 1'b0, 16'd1);
        take_result("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
